// File: rtl/pc_fetch_unit_if.sv
// Signal bundle between the PC fetch stage and the Control block / datapath.
interface pc_fetch_unit_if;
  logic [2:0]  pcsrc;
  logic        branch_cond;
  logic [15:0] imm16;
  logic [25:0] jtarget;
  logic [31:0] rs_data;
  logic        irq_in;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        irq;

  modport master (
    output pcsrc, branch_cond, imm16, jtarget, rs_data, irq_in,
    input  pc, pc_plus4, irq
  );

  modport slave (
    input  pcsrc, branch_cond, imm16, jtarget, rs_data, irq_in,
    output pc, pc_plus4, irq
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: PC register, next-PC selection and the
// synchronised, edge-detected, supervisor-masked interrupt request.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VEC   = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VEC   = 32'h8000_0004,
  parameter logic [31:0] XADR_VEC    = 32'h8000_0008,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  pc_fetch_unit_if.slave   bus
);

  localparam logic [2:0] PCSRC_SEQ    = 3'd0;
  localparam logic [2:0] PCSRC_BRANCH = 3'd1;
  localparam logic [2:0] PCSRC_JUMP   = 3'd2;
  localparam logic [2:0] PCSRC_JR     = 3'd3;
  localparam logic [2:0] PCSRC_INTR   = 3'd4;
  localparam logic [2:0] PCSRC_EXCP   = 3'd5;

  logic [31:0]            pc_q, pc_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic                   pending_q, pending_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] branch_tgt_s;
  logic [31:0] jump_tgt_s;
  logic [31:0] rjump_tgt_s;
  logic [30:0] imm_ext_s;
  logic        irq_sync_s;
  logic        rise_s;

  // Candidate targets; only the register jump may change the supervisor bit.
  always_comb begin
    pc_plus4_s   = {pc_q[31], pc_q[30:0] + 31'd4};
    imm_ext_s    = {{13{bus.imm16[15]}}, bus.imm16, 2'b00};
    branch_tgt_s = {pc_q[31], pc_plus4_s[30:0] + imm_ext_s};
    jump_tgt_s   = {pc_q[31], pc_plus4_s[30:28], bus.jtarget, 2'b00};
    rjump_tgt_s  = bus.rs_data & 32'hFFFF_FFFC;
  end

  // Next-PC select; undefined encodings fall back to the exception vector.
  always_comb begin
    pc_d = pc_plus4_s;
    case (bus.pcsrc)
      PCSRC_SEQ:    pc_d = pc_plus4_s;
      PCSRC_BRANCH: begin
        if (bus.branch_cond) begin
          pc_d = branch_tgt_s;
        end else begin
          pc_d = pc_plus4_s;
        end
      end
      PCSRC_JUMP:   pc_d = jump_tgt_s;
      PCSRC_JR:     pc_d = rjump_tgt_s;
      PCSRC_INTR:   pc_d = ILLOP_VEC;
      PCSRC_EXCP:   pc_d = XADR_VEC;
      default:      pc_d = XADR_VEC;
    endcase
  end

  // Interrupt synchroniser, rising-edge detect and sticky pending flag.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], bus.irq_in};
    irq_sync_s = sync_q[SYNC_STAGES-1];
    edge_d     = irq_sync_s;
    rise_s     = irq_sync_s & ~edge_q;
    if (rise_s) begin
      pending_d = 1'b1;
    end else if (bus.pcsrc == PCSRC_INTR) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_VEC;
      sync_q    <= {SYNC_STAGES{1'b0}};
      edge_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      sync_q    <= sync_d;
      edge_q    <= edge_d;
      pending_q <= pending_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4_s;
  assign bus.irq      = pending_q & ~pc_q[31];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed cases plus random traffic
// checked against a behavioural next-PC / interrupt model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pp4;
    logic        irq;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_fetch_unit_if fbus ();

  pc_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (fbus)
  );

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Reference model state: architectural PC, pending flag, and the last
  // three irq_in values sampled on rising edges (newest first).
  logic [31:0] m_pc;
  logic        m_pending;
  logic        m_s0, m_s1, m_s2;

  function automatic logic [31:0] plus4(input logic [31:0] p);
    return (p & 32'h8000_0000) | ((p + 32'd4) & 32'h7FFF_FFFF);
  endfunction

  task automatic model_reset();
    m_pc      = RESET_VEC;
    m_pending = 1'b0;
    m_s0      = 1'b0;
    m_s1      = 1'b0;
    m_s2      = 1'b0;
  endtask

  task automatic compare(input string nm, input exp_t e);
    vectors++;
    if (fbus.pc !== e.pc || fbus.pc_plus4 !== e.pp4 || fbus.irq !== e.irq) begin
      miscompares++;
      $display("FAIL %s: got pc=%h pc_plus4=%h irq=%b, expected pc=%h pc_plus4=%h irq=%b",
               nm, fbus.pc, fbus.pc_plus4, fbus.irq, e.pc, e.pp4, e.irq);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.pc  = RESET_VEC;
    e.pp4 = RESET_VEC + 32'd4;
    e.irq = 1'b0;
    return e;
  endfunction

  // Apply one cycle of stimulus and queue the state expected after the edge.
  task automatic drive(input string nm, input logic [2:0] src, input logic bc,
                       input logic [15:0] imm, input logic [25:0] jt,
                       input logic [31:0] rs, input logic irqin);
    logic [31:0] nxt, p4, off;
    logic        rise;
    exp_t        e;
    @(negedge clk);
    fbus.pcsrc       = src;
    fbus.branch_cond = bc;
    fbus.imm16       = imm;
    fbus.jtarget     = jt;
    fbus.rs_data     = rs;
    fbus.irq_in      = irqin;
    p4  = plus4(m_pc);
    off = {{14{imm[15]}}, imm, 2'b00};
    case (src)
      3'd0:    nxt = p4;
      3'd1:    nxt = bc ? ((m_pc & 32'h8000_0000) | ((p4 + off) & 32'h7FFF_FFFF)) : p4;
      3'd2:    nxt = (m_pc & 32'h8000_0000) | (p4 & 32'h7000_0000) | {4'b0000, jt, 2'b00};
      3'd3:    nxt = {rs[31:2], 2'b00};
      3'd4:    nxt = ILLOP_VEC;
      default: nxt = XADR_VEC;
    endcase
    // A new synchronised level becomes a rise two edges after it is sampled.
    rise = m_s1 & ~m_s2;
    if (rise) m_pending = 1'b1;
    else if (src == 3'd4) m_pending = 1'b0;
    m_s2 = m_s1;
    m_s1 = m_s0;
    m_s0 = irqin;
    m_pc = nxt;
    e.pc  = nxt;
    e.pp4 = plus4(nxt);
    e.irq = m_pending & ~nxt[31];
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic seq(input string nm, input logic irqin);
    drive(nm, 3'd0, 1'b0, 16'h0000, 26'h0, 32'h0, irqin);
  endtask

  task automatic jr(input string nm, input logic [31:0] rs, input logic irqin);
    drive(nm, 3'd3, 1'b0, 16'h0000, 26'h0, rs, irqin);
  endtask

  // Monitor: outputs are valid every cycle, so check just after each edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        compare(nm, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  initial begin
    fbus.pcsrc = 3'd0; fbus.branch_cond = 1'b0; fbus.imm16 = 16'h0;
    fbus.jtarget = 26'h0; fbus.rs_data = 32'h0; fbus.irq_in = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare("reset_state", reset_exp());
    @(posedge clk); #2 reset = 1'b1;

    seq("release_1", 1'b0);
    seq("release_2", 1'b0);
    seq("release_3", 1'b0);

    jr("jr_0x100", 32'h0000_0100, 1'b0);
    drive("branch_taken", 3'd1, 1'b1, 16'hFFFE, 26'h0, 32'h0, 1'b0);
    jr("jr_0x100b", 32'h0000_0100, 1'b0);
    drive("branch_not_taken", 3'd1, 1'b0, 16'hFFFE, 26'h0, 32'h0, 1'b0);

    jr("jr_sup_0x40", 32'h8000_0040, 1'b0);
    drive("jump_keep_sup", 3'd2, 1'b0, 16'h0, 26'h000_0010, 32'h0, 1'b0);
    jr("jr_clear_sup", 32'h0040_0007, 1'b0);

    drive("vec_illop", 3'd4, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    drive("vec_xadr", 3'd5, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    drive("vec_undef7", 3'd7, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    drive("vec_undef6", 3'd6, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);

    jr("jr_7ffffffc", 32'h7FFF_FFFC, 1'b0);
    seq("wrap_user", 1'b0);
    jr("jr_fffffffc", 32'hFFFF_FFFC, 1'b0);
    seq("wrap_sup", 1'b0);

    jr("jr_0x10", 32'h0000_0010, 1'b0);
    seq("irq_lat_1", 1'b1);
    seq("irq_lat_2", 1'b1);
    seq("irq_lat_3", 1'b1);
    drive("irq_taken", 3'd4, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1);
    jr("irq_no_rearm_jr", 32'h0000_0020, 1'b1);
    for (int i = 0; i < 4; i++) seq("irq_level_held", 1'b1);

    jr("enter_sup", 32'h8000_0100, 1'b0);
    for (int i = 0; i < 3; i++) seq("irq_low", 1'b0);
    for (int i = 0; i < 4; i++) seq("irq_masked", 1'b1);
    jr("deliver_on_jr", 32'h0000_0200, 1'b1);
    drive("take_again", 3'd4, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1);
    jr("back_user_clear", 32'h0000_0300, 1'b0);
    seq("drop_1", 1'b0);
    seq("drop_2", 1'b0);
    seq("coinc_1", 1'b1);
    seq("coinc_2", 1'b1);
    drive("coinc_take", 3'd4, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1);
    jr("coinc_deliver", 32'h0000_0400, 1'b1);
    seq("pending_user", 1'b1);

    @(posedge clk); #3 reset = 1'b0;
    fbus.irq_in = 1'b0;
    model_reset();
    #1 compare("async_reset", reset_exp());
    @(posedge clk); #1 compare("reset_hold", reset_exp());
    @(posedge clk); #2 reset = 1'b1;
    seq("post_reset", 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [2:0]  src;
      logic        irqv;
      int          r;
      r = int'($urandom_range(0, 15));
      if (r < 6) src = 3'd0;
      else if (r < 9) src = 3'd1;
      else if (r < 11) src = 3'd2;
      else if (r < 13) src = 3'd3;
      else src = 3'($urandom_range(4, 7));
      irqv = ($urandom_range(0, 7) == 0) ? ~m_s0 : m_s0;
      drive("random", src, 1'($urandom_range(0, 1)), 16'($urandom),
            26'($urandom), $urandom, irqv);
    end

    @(posedge clk); #3;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
